// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - AXI-Lite initiator turning single commands into AXI-Lite reads/writes
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid/rsp_ready         response handshake (rsp_rdata, rsp_err)
//   busy                        high whenever a transaction or response is pending
//   aw*/w*                      AXI-Lite write address/data channels (no B channel)
//   ar*/r*                      AXI-Lite read address/data channels
module axi_lite_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 256,
    parameter int pTMO_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    // The counter holds cycles already spent in the transaction, so the abort
    // fires in the cycle where it would step onto pTIMEOUT.
    localparam logic [pTMO_WIDTH-1:0] TMO_LAST = pTMO_WIDTH'(pTIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [pADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [pADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [pDATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [pDATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [pTMO_WIDTH-1:0]   tmo_q, tmo_d;

    logic tmo_hit;
    logic aw_fin;
    logic w_fin;

    assign tmo_hit = (pTIMEOUT != 0) && (tmo_q == TMO_LAST);
    // A channel is finished if it handshakes now or already did earlier.
    assign aw_fin  = (awvalid_q & awready) | ~awvalid_q;
    assign w_fin   = (wvalid_q & wready) | ~wvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WRITE: begin
                tmo_d = tmo_q + pTMO_WIDTH'(1);
                if (aw_fin && w_fin) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (tmo_hit) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    if (awvalid_q && awready) awvalid_d = 1'b0;
                    if (wvalid_q && wready)   wvalid_d  = 1'b0;
                end
            end
            S_RD_ADDR: begin
                tmo_d = tmo_q + pTMO_WIDTH'(1);
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (tmo_hit) begin
                    arvalid_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RD_DATA: begin
                tmo_d = tmo_q + pTMO_WIDTH'(1);
                if (rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (tmo_hit) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign rready    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master with a register slave model
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        awvalid, awready;
    logic [11:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic        arvalid, arready;
    logic [11:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axi_lite_master #(
        .pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTIMEOUT(8), .pTMO_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register slave model: wready only after the aw handshake (unless w_early),
    // coefficient window 0x20-0x4F answers reads two cycles later.
    int          aw_stall = 0;
    bit          w_early  = 1'b0;
    bit          ar_dead  = 1'b0;
    int          aw_wait;
    logic        aw_got, w_got, rd_pending;
    logic [1:0]  rd_cnt;
    logic [11:0] aw_addr_l;
    logic [31:0] w_data_l, rd_data_l;
    logic [31:0] mem [0:63];

    assign awready = awvalid && (aw_wait >= aw_stall);
    assign wready  = wvalid && (w_early || aw_got);
    assign arready = arvalid && !ar_dead;
    assign rvalid  = rd_pending && (rd_cnt == 2'd0);
    assign rdata   = rd_data_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait    <= 0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            rd_pending <= 1'b0;
            rd_cnt     <= 2'd0;
            aw_addr_l  <= '0;
            w_data_l   <= '0;
            rd_data_l  <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_l <= awaddr; end
            if (wvalid && wready)   begin w_got <= 1'b1;  w_data_l <= wdata;   end
            if (aw_got && w_got) begin
                mem[aw_addr_l[7:2]] <= w_data_l;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (arvalid && arready) begin
                rd_pending <= 1'b1;
                rd_cnt     <= (araddr >= 12'h020 && araddr <= 12'h04F) ? 2'd2 : 2'd0;
                rd_data_l  <= mem[araddr[7:2]];
            end else if (rvalid && rready) begin
                rd_pending <= 1'b0;
            end else if (rd_pending && rd_cnt != 2'd0) begin
                rd_cnt <= rd_cnt - 2'd1;
            end
        end
    end

    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: pops an expectation when a response first appears, then
    // checks the response stays stable and the bus stays quiet while held.
    bit          have_rsp = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    always @(negedge clk) begin
        if (!rst_n) begin
            have_rsp = 1'b0;
        end else begin
            chk("rready_tracks_slave", {31'b0, rready}, {31'b0, rd_pending});
            if (rsp_valid) begin
                chk("cmd_ready_during_rsp", {31'b0, cmd_ready}, 32'd0);
                chk("axi_quiet_during_rsp", {29'b0, awvalid, wvalid, arvalid}, 32'd0);
                if (!have_rsp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=1 required=0 at cycle %0d", cyc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                        chk("rsp_latency", cyc - e.cyc, e.lat);
                    end
                    have_rsp   = 1'b1;
                    held_rdata = rsp_rdata;
                    held_err   = rsp_err;
                end else begin
                    chk("rsp_rdata_stable", rsp_rdata, held_rdata);
                    chk("rsp_err_stable", {31'b0, rsp_err}, {31'b0, held_err});
                end
                if (rsp_ready) have_rsp = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int n = 0;
        exp_t e;
        while (!cmd_ready && n < 50) begin step(); n++; end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout actual=0 required=1 at cycle %0d", cyc);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc;
        e.lat   = exp_lat;
        exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin step(); n++; end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle at cycle %0d", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_axi_valids", {28'b0, awvalid, wvalid, arvalid, rready}, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_addrs", {8'b0, awaddr, araddr}, 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        step();

        // Length register write then readback.
        issue(1'b1, 12'h010, 32'h0000_000A, 32'h0, 1'b0, 3);
        wait_idle();
        issue(1'b0, 12'h010, 32'h0, 32'h0000_000A, 1'b0, 3);
        wait_idle();

        // Coefficient write then read with two extra slave cycles.
        issue(1'b1, 12'h024, 32'hFFFF_FFF6, 32'h0, 1'b0, 3);
        wait_idle();
        issue(1'b0, 12'h024, 32'h0, 32'hFFFF_FFF6, 1'b0, 5);
        wait_idle();

        // awready held low 4 cycles while wready is already up.
        aw_stall = 4;
        w_early  = 1'b1;
        issue(1'b1, 12'h030, 32'h1234_5678, 32'h0, 1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_wvalid_dropped", {31'b0, wvalid}, 32'd0);
            chk("stall_awvalid_held", {31'b0, awvalid}, 32'd1);
        end
        wait_idle();
        aw_stall = 0;
        w_early  = 1'b0;
        repeat (3) step();
        issue(1'b0, 12'h030, 32'h0, 32'h1234_5678, 1'b0, 5);
        wait_idle();

        // arready tied low: abort after 8 cycles in RD_ADDR.
        ar_dead = 1'b1;
        issue(1'b0, 12'h000, 32'h0, 32'h0, 1'b1, 9);
        repeat (7) step();
        chk("tmo_arvalid_cycle8", {31'b0, arvalid}, 32'd1);
        step();
        chk("tmo_arvalid_dropped", {31'b0, arvalid}, 32'd0);
        wait_idle();
        ar_dead = 1'b0;
        issue(1'b0, 12'h010, 32'h0, 32'h0000_000A, 1'b0, 3);
        wait_idle();

        // Response held 10 cycles while commands toggle.
        rsp_ready = 1'b0;
        issue(1'b0, 12'h010, 32'h0, 32'h0000_000A, 1'b0, 3);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin step(); n++; end
            chk("hold_rsp_seen", {31'b0, rsp_valid}, 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            cmd_valid = i[0];
            cmd_write = 1'b1;
            cmd_addr  = 12'h014;
            cmd_wdata = 32'h0000_0055;
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        issue(1'b0, 12'h014, 32'h0, 32'h0, 1'b0, 3);
        wait_idle();

        // Reset in the middle of RD_DATA.
        issue(1'b0, 12'h024, 32'h0, 32'hFFFF_FFF6, 1'b0, 5);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rready", {31'b0, rready}, 32'd0);
        chk("async_rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        issue(1'b0, 12'h024, 32'h0, 32'hFFFF_FFF6, 1'b0, 5);
        wait_idle();

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
